// File: rtl/reg_bank.sv
// Multi-channel register bank: parallel load, addressed write, circular rotate,
// clear, registered addressed read and a live nonzero-channel count.
module reg_bank #(
    parameter  int XLEN   = 32,
    parameter  int NUM_CH = 4,
    localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_ld_all,
    input  logic [NUM_CH*XLEN-1:0]   i_ld_data,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [XLEN-1:0]          i_wr_data,
    input  logic                     i_rot_en,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    output logic [XLEN-1:0]          o_rd_data,
    output logic [NUM_CH*XLEN-1:0]   o_out_flat,
    output logic [CNT_W-1:0]         o_nz_count,
    output logic                     o_rot_done,
    output logic                     o_wr_err
);

    localparam logic [ADDR_W:0]   LP_NUM_CH  = (ADDR_W + 1)'(NUM_CH);
    localparam logic [ADDR_W-1:0] LP_LAST_CH = ADDR_W'(NUM_CH - 1);

    logic [XLEN-1:0]   r_ch [NUM_CH];
    logic [ADDR_W-1:0] r_rot_cnt;
    logic [XLEN-1:0]   r_rd_data;
    logic              r_rot_done;
    logic              r_wr_err;

    logic              w_wr_oob;
    logic              w_rd_oob;
    logic              w_wr_active;
    logic [XLEN-1:0]   w_rd_sel;
    logic [CNT_W-1:0]  w_nz_count;

    // Compare against NUM_CH itself so non-power-of-two banks reject the unused codes.
    assign w_wr_oob    = ({1'b0, i_wr_addr} >= LP_NUM_CH);
    assign w_rd_oob    = ({1'b0, i_rd_addr} >= LP_NUM_CH);
    assign w_wr_active = i_wr_en & ~i_clr & ~i_ld_all & ~i_rot_en;

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_rd_addr == ADDR_W'(i)) begin
                w_rd_sel = r_ch[i];
            end
        end
    end

    always_comb begin
        w_nz_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_nz_count = w_nz_count + CNT_W'(r_ch[i] != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ch[i] <= '0;
            end
            r_rot_cnt  <= '0;
            r_rd_data  <= '0;
            r_rot_done <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            // Read samples the pre-update contents; a masked write never raises an error.
            r_rd_data  <= w_rd_oob ? '0 : w_rd_sel;
            r_wr_err   <= w_rd_oob | (w_wr_active & w_wr_oob);
            r_rot_done <= 1'b0;

            if (i_clr) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_ch[i] <= '0;
                end
                r_rot_cnt <= '0;
            end else if (i_ld_all) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_ch[i] <= i_ld_data[i*XLEN +: XLEN];
                end
                r_rot_cnt <= '0;
            end else if (i_rot_en) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_ch[i] <= r_ch[(i + 1) % NUM_CH];
                end
                if (r_rot_cnt == LP_LAST_CH) begin
                    r_rot_cnt  <= '0;
                    r_rot_done <= 1'b1;
                end else begin
                    r_rot_cnt <= r_rot_cnt + 1'b1;
                end
            end else if (i_wr_en && !w_wr_oob) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (i_wr_addr == ADDR_W'(i)) begin
                        r_ch[i] <= i_wr_data;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign o_out_flat[g*XLEN +: XLEN] = r_ch[g];
    end

    assign o_rd_data  = r_rd_data;
    assign o_nz_count = w_nz_count;
    assign o_rot_done = r_rot_done;
    assign o_wr_err   = r_wr_err;

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
Parametrised multi-channel register bank, the next generation of the single load-enable register in the Maxnet datapath. It holds NUM_CH words of XLEN bits (e.g. Maxnet neuron activations). Access modes:
- parallel load of all channels
- single-channel addressed write
- circular rotate across channels, with a wrap counter
- synchronous clear
It also provides a registered addressed read port and a live count of nonzero channels, which the Maxnet controller uses for termination (one winner left).

Parameters:
XLEN, 32, bit width of each channel word
NUM_CH, 4, number of channels (>= 2)
ADDR_W, $clog2(NUM_CH), channel address width (derived, localparam-style; minimum 1)
CNT_W, $clog2(NUM_CH+1), width of nz_count (derived)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous clear of all channel contents
ld_all  input  1  parallel load of all channels from ld_data
ld_data  input  NUM_CH*XLEN  flattened load data; channel i = bits [i*XLEN +: XLEN]
wr_en  input  1  single-channel write strobe
wr_addr  input  ADDR_W  channel index for write
wr_data  input  XLEN  write data
rot_en  input  1  rotate channels down by one position
rd_addr  input  ADDR_W  channel index for read
rd_data  output  XLEN  registered read data
out_flat  output  NUM_CH*XLEN  current contents of all channels, flattened, same packing as ld_data
nz_count  output  CNT_W  number of channels whose current content is nonzero
rot_done  output  1  one-cycle pulse when rotation count wraps
wr_err  output  1  one-cycle pulse on an out-of-range write or read

Behaviour:
- Reset: all outputs and internal state reset synchronously to 0 when rst=1 at a rising edge of clk.
  - Covers all channels, rd_data, rot_cnt, rot_done, wr_err.
  - rst overrides every other input, including mid-rotation; rot_cnt returns to 0.
- Channel update priority per cycle (highest first): rst > clr > ld_all > rot_en > wr_en. Exactly one update action occurs per cycle.
  - clr: all channels <= 0; rot_cnt <= 0.
  - ld_all: ch[i] <= ld_data[i*XLEN +: XLEN] for all i; rot_cnt <= 0.
  - rot_en: ch[i] <= ch[i+1] for i < NUM_CH-1, and ch[NUM_CH-1] <= ch[0] (full circular, no data loss).
    - rot_cnt increments modulo NUM_CH.
    - rot_done=1 in the cycle after the update where rot_cnt was NUM_CH-1 (rot_cnt wraps to 0); otherwise 0.
  - wr_en: if wr_addr < NUM_CH, ch[wr_addr] <= wr_data; else no change and wr_err=1 next cycle.
  - A write masked by a higher-priority action is dropped silently, with no wr_err.
- Read path, latency 1 cycle:
  - rd_data <= ch[rd_addr], sampled from contents before the same-cycle update (read-before-write).
  - If rd_addr >= NUM_CH: rd_data <= 0 and wr_err=1 next cycle.
  - The read is performed every cycle; there is no read enable.
- wr_err: registered OR of the out-of-range write and out-of-range read conditions; a one-cycle pulse per offending cycle.
- out_flat: direct register outputs, 0-cycle combinational path from the state; reflects the update one cycle after the command.
- nz_count: combinational population count over channels of (ch[i] != 0), derived from the register contents only.
  - Range 0..NUM_CH.
  - No arithmetic on channel data; content is treated as a raw bit vector.
- Non-power-of-two NUM_CH is supported: address compare against NUM_CH, not 2^ADDR_W.
- No X propagation: every register has a defined value after the first reset cycle.

Test Plan:
- XLEN=8, NUM_CH=4; rst=1 for 2 cycles -> out_flat=0x00000000, rd_data=0, nz_count=0, rot_done=0, wr_err=0.
- ld_all with ld_data=0x04030201 -> next cycle out_flat=0x04030201, nz_count=4. Then rd_addr=2 -> rd_data=0x03 one cycle later.
- After that load, rot_en=1 for 4 consecutive cycles:
  - out_flat sequence 0x01040302, 0x02010403, 0x03020104, 0x04030201.
  - rot_done=1 exactly in the cycle showing 0x04030201.
- wr_en=1, wr_addr=1, wr_data=0x00 on contents 0x04030201 -> out_flat=0x04030001, nz_count=3. Same cycle rd_addr=1 -> rd_data=0x02 (old value).
- wr_en=1 and ld_all=1 in the same cycle, wr_addr=0, wr_data=0xFF, ld_data=0x11223344 -> out_flat=0x11223344, wr_err=0. With NUM_CH=3 (ADDR_W=2), wr_addr=3 -> no change, wr_err pulses 1 cycle.
- Mid-rotation (rot_cnt=2), assert rst one cycle with rot_en held high -> all channels 0, rot_cnt restarts. rot_done fires only after 4 further rotations.
